// File: rtl/issue_unit.sv
// Issue scheduler: grants the int, ld/st, mult and div issue queues against a
// shared single-port CDB, tracking future write-back slots and divider occupancy.
module issue_unit #(
    parameter int INT_LAT  = 1,
    parameter int LS_LAT   = 1,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 6,
    parameter int SLOT_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iq_int_rdy,
    input  logic              iq_ls_rdy,
    input  logic              iq_mult_rdy,
    input  logic              iq_div_rdy,
    input  logic              cdb_flush,
    output logic              iu_int_r_en,
    output logic              iu_ls_r_en,
    output logic              iu_mult_r_en,
    output logic              iu_div_r_en,
    output logic              iu_div_busy,
    output logic [SLOT_W-1:0] iu_cdb_slot
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    logic [SLOT_W-1:0] slot_r;
    logic [CNT_W-1:0]  div_cnt_r;
    logic              lru_r;

    logic [SLOT_W-1:0] used_s;
    logic              allow_s;
    logic              div_gnt_s;
    logic              mult_gnt_s;
    logic              int_ok_s;
    logic              ls_ok_s;
    logic              int_gnt_s;
    logic              ls_gnt_s;
    logic              div_busy_s;

    // One-hot mask for a result landing on the CDB lat cycles from now.
    function automatic logic [SLOT_W-1:0] lat_bit(input int lat);
        lat_bit = {{(SLOT_W-1){1'b0}}, 1'b1} << (lat - 1);
    endfunction

    assign div_busy_s = (div_cnt_r != {CNT_W{1'b0}});

    // Grant arbitration in priority order; used_s accumulates slots claimed so far.
    always_comb begin
        used_s     = {SLOT_W{1'b0}};
        int_gnt_s  = 1'b0;
        ls_gnt_s   = 1'b0;
        allow_s    = !reset && !cdb_flush;

        div_gnt_s  = allow_s && iq_div_rdy && !div_busy_s && !slot_r[DIV_LAT-1];
        used_s     = used_s | (div_gnt_s ? lat_bit(DIV_LAT) : {SLOT_W{1'b0}});

        mult_gnt_s = allow_s && iq_mult_rdy && !(slot_r[MULT_LAT-1] || used_s[MULT_LAT-1]);
        used_s     = used_s | (mult_gnt_s ? lat_bit(MULT_LAT) : {SLOT_W{1'b0}});

        int_ok_s   = allow_s && iq_int_rdy && !(slot_r[INT_LAT-1] || used_s[INT_LAT-1]);
        ls_ok_s    = allow_s && iq_ls_rdy  && !(slot_r[LS_LAT-1]  || used_s[LS_LAT-1]);

        // Same-latency int/ls collide on the CDB: the LRU bit picks the one not served last.
        if ((INT_LAT == LS_LAT) && int_ok_s && ls_ok_s) begin
            int_gnt_s = !lru_r;
            ls_gnt_s  = lru_r;
        end else begin
            int_gnt_s = int_ok_s;
            ls_gnt_s  = ls_ok_s;
        end

        used_s = used_s | (int_gnt_s ? lat_bit(INT_LAT) : {SLOT_W{1'b0}});
        used_s = used_s | (ls_gnt_s  ? lat_bit(LS_LAT)  : {SLOT_W{1'b0}});
    end

    // Reservation shift register, divider countdown and int/ls LRU state.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_r    <= {SLOT_W{1'b0}};
            div_cnt_r <= {CNT_W{1'b0}};
            lru_r     <= 1'b0;
        end else begin
            slot_r <= (slot_r | used_s) >> 1;

            if (div_gnt_s) begin
                div_cnt_r <= CNT_W'(DIV_LAT - 1);
            end else if (div_busy_s) begin
                div_cnt_r <= div_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                div_cnt_r <= div_cnt_r;
            end

            if (int_gnt_s) begin
                lru_r <= 1'b1;
            end else if (ls_gnt_s) begin
                lru_r <= 1'b0;
            end else begin
                lru_r <= lru_r;
            end
        end
    end

    assign iu_int_r_en  = int_gnt_s;
    assign iu_ls_r_en   = ls_gnt_s;
    assign iu_mult_r_en = mult_gnt_s;
    assign iu_div_r_en  = div_gnt_s;
    assign iu_div_busy  = div_busy_s;
    assign iu_cdb_slot  = slot_r;

endmodule

// File: tb/tb_issue_unit.sv
// Vector-table bench for issue_unit: each row is one clock cycle of inputs with
// the grants, divider busy flag and reservation vector expected during it.
module tb_issue_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       iq_int_rdy, iq_ls_rdy, iq_mult_rdy, iq_div_rdy, cdb_flush;
    logic       iu_int_r_en, iu_ls_r_en, iu_mult_r_en, iu_div_r_en, iu_div_busy;
    logic [5:0] iu_cdb_slot;

    typedef struct {
        logic       rst, ir, lr, mr, dr, fl;
        logic [3:0] en;    // {div, mult, ls, int}
        logic       busy;
        logic [5:0] slot;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    issue_unit dut (
        .clk          (clk),
        .reset        (reset),
        .iq_int_rdy   (iq_int_rdy),
        .iq_ls_rdy    (iq_ls_rdy),
        .iq_mult_rdy  (iq_mult_rdy),
        .iq_div_rdy   (iq_div_rdy),
        .cdb_flush    (cdb_flush),
        .iu_int_r_en  (iu_int_r_en),
        .iu_ls_r_en   (iu_ls_r_en),
        .iu_mult_r_en (iu_mult_r_en),
        .iu_div_r_en  (iu_div_r_en),
        .iu_div_busy  (iu_div_busy),
        .iu_cdb_slot  (iu_cdb_slot)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, ir, lr, mr, dr, fl,
                                input logic [3:0] en, input logic busy,
                                input logic [5:0] slot);
        vec_t v;
        v.rst = rst; v.ir = ir; v.lr = lr; v.mr = mr; v.dr = dr; v.fl = fl;
        v.en = en; v.busy = busy; v.slot = slot;
        return v;
    endfunction

    // Drive one cycle just after the edge, queue its expectation, check at negedge.
    task automatic apply(input vec_t v);
        vec_t       e;
        logic [3:0] got_en;
        @(posedge clk);
        #1;
        reset = v.rst; iq_int_rdy = v.ir; iq_ls_rdy = v.lr;
        iq_mult_rdy = v.mr; iq_div_rdy = v.dr; cdb_flush = v.fl;
        exp_q.push_back(v);
        @(negedge clk);
        e      = exp_q.pop_front();
        got_en = {iu_div_r_en, iu_mult_r_en, iu_ls_r_en, iu_int_r_en};
        if (got_en !== e.en) begin
            n_fail++;
            $display("FAIL r_en vec %0d: got %b want %b", n_vec, got_en, e.en);
        end
        if (iu_div_busy !== e.busy) begin
            n_fail++;
            $display("FAIL div_busy vec %0d: got %b want %b", n_vec, iu_div_busy, e.busy);
        end
        if (iu_cdb_slot !== e.slot) begin
            n_fail++;
            $display("FAIL cdb_slot vec %0d: got %b want %b", n_vec, iu_cdb_slot, e.slot);
        end
        n_vec++;
    endtask

    initial begin
        reset = 1'b1; iq_int_rdy = 1'b1; iq_ls_rdy = 1'b1;
        iq_mult_rdy = 1'b1; iq_div_rdy = 1'b1; cdb_flush = 1'b0;

        // reset with everything ready, then idle
        vecs.push_back(mk(1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 4'b0000,1'b0,6'b000000));
        vecs.push_back(mk(1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 4'b0000,1'b0,6'b000000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b0,6'b000000));
        // int/ls alternation starting with int
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0001,1'b0,6'b000000));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0010,1'b0,6'b000000));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0001,1'b0,6'b000000));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0010,1'b0,6'b000000));
        // mult at t0 blocks int at t3, int granted at t4
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'b0100,1'b0,6'b000000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b0,6'b000100));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b0,6'b000010));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b0,6'b000001));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b0001,1'b0,6'b000000));
        // div at t0 with rdy held: busy t1..t5, next grant t6
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1000,1'b0,6'b000000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b0000,1'b1,6'b010000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b0000,1'b1,6'b001000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b0000,1'b1,6'b000100));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b0000,1'b1,6'b000010));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b0000,1'b1,6'b000001));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1000,1'b0,6'b000000));
        // that div is t0 again: mult blocked at t2, granted at t3
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b1,6'b010000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'b0000,1'b1,6'b001000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'b0100,1'b1,6'b000100));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b1,6'b000110));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b1,6'b000011));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b0,6'b000001));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b0,6'b000000));
        // all ready: div, mult and ls (LRU favours ls after last int) in one cycle
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'b1110,1'b0,6'b000000));
        // flush: no grants, reservations keep shifting
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 4'b0000,1'b1,6'b010100));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 4'b0000,1'b1,6'b001010));
        // reset while div busy clears everything next cycle
        vecs.push_back(mk(1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 4'b0000,1'b1,6'b000101));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,1'b0,6'b000000));

        foreach (vecs[i]) apply(vecs[i]);

        // LRU must return to int-favoured after a reset that follows an int grant
        apply(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b0001,1'b0,6'b000000));
        apply(mk(1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 4'b0000,1'b0,6'b000000));
        apply(mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0001,1'b0,6'b000000));
        apply(mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0010,1'b0,6'b000000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
